// File: rtl/pipectrl_pkg.sv
// pipectrl_pkg: shared constants and types for the pipeline hazard/redirect
// controller.
//   - Stage indices into the per-stage stall/flush vectors.
//   - Redirect cause encodings. Their numeric order is also their priority,
//     so the pending register compares causes directly.
//   - M-type stall FSM state type and state constants.
package pipectrl_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EXE = 3;

    localparam logic [1:0] CAUSE_JUMP = 2'd0;
    localparam logic [1:0] CAUSE_RET  = 2'd1;
    localparam logic [1:0] CAUSE_TRAP = 2'd2;

    typedef logic [0:0] mstate_t;

    localparam mstate_t ST_IDLE = 1'b0;
    localparam mstate_t ST_BUSY = 1'b1;

endpackage

// File: rtl/pipectrl_redirect_q.sv
// pipectrl_redirect_q: priority-merge pending-redirect register.
// An incoming redirect event is merged with any held one. A new event wins
// when its cause is at least the held cause, so equal causes take the newer
// event. When the PC is not stalled, the merged redirect goes out in the same
// cycle and the register clears. When the PC is stalled, the merged redirect
// is captured, and the output shows only what was already held. A captured
// redirect therefore becomes visible from the next cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   evt_valid/cause/addr  this cycle's winning redirect event
//   stall_pc              PC stage held this cycle
//   valid/cause/addr      redirect presented to the PC (zero when not valid)
//   pending               a redirect is held from an earlier cycle
module pipectrl_redirect_q
    import pipectrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            evt_valid,
    input  logic [1:0]      evt_cause,
    input  logic [XLEN-1:0] evt_addr,
    input  logic            stall_pc,
    output logic            valid,
    output logic [1:0]      cause,
    output logic [XLEN-1:0] addr,
    output logic            pending
);

    logic            pend_valid;
    logic [1:0]      pend_cause;
    logic [XLEN-1:0] pend_addr;

    logic            take_new;
    logic            mrg_valid;
    logic [1:0]      mrg_cause;
    logic [XLEN-1:0] mrg_addr;

    always_comb begin
        take_new  = evt_valid && (!pend_valid || (evt_cause >= pend_cause));
        mrg_valid = pend_valid | evt_valid;
        mrg_cause = take_new ? evt_cause : pend_cause;
        mrg_addr  = take_new ? evt_addr  : pend_addr;
    end

    // Cause and address are cleared along with valid. Because of this, an
    // empty register already reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_cause <= CAUSE_JUMP;
            pend_addr  <= '0;
        end else if (!stall_pc) begin
            pend_valid <= 1'b0;
            pend_cause <= CAUSE_JUMP;
            pend_addr  <= '0;
        end else begin
            pend_valid <= mrg_valid;
            pend_cause <= mrg_cause;
            pend_addr  <= mrg_addr;
        end
    end

    always_comb begin
        if (stall_pc) begin
            valid = pend_valid;
            cause = pend_cause;
            addr  = pend_addr;
        end else begin
            valid = mrg_valid;
            cause = mrg_cause;
            addr  = mrg_addr;
        end
    end

    assign pending = pend_valid;

endmodule

// File: rtl/pipectrl_v2.sv
// pipectrl_v2: pipeline hazard and redirect controller for the RV32IM core.
// Produces per-stage stall/flush vectors. Owns the multi-cycle M-type stall
// FSM, which has a timeout and a kill. Holds a jump/trap/return that arrives
// while the PC is stalled, and delivers it once the PC stall drops.
// Optional feature: define PIPECTRL_PERF_EN to build the stall-cycle and
// redirect-delivery performance counters. When it is not defined, both
// counter outputs are tied to zero.
// Parameters: XLEN address width, NSTAGES pipeline registers (>=5),
//   MTYPE_TIMEOUT maximum BUSY cycles (2..255).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   loaduse_hazard_i                    load-use hazard from ID
//   je_i, jump_addr_i                   taken branch/jump from EXE
//   mtype_start_i, mtype_done_i         mul/div issue / result ready
//   ext_stall_i                         LSU bus wait
//   trap_taken_i, trap_entry_i          trap from CSR
//   system_ret_i, system_retaddr_i      xRET from CSR
//   stall_o, flush_o                    per-stage hold / bubble insert
//   redirect_valid_o/addr_o/cause_o     PC load (cause 0 jump, 1 ret, 2 trap)
//   mtype_busy_o                        M-type FSM in BUSY
//   mtype_kill_o, mtype_timeout_o       registered one-cycle pulses
//   stall_cycles_o, flush_events_o      performance counters
module pipectrl_v2
    import pipectrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int NSTAGES       = 6,
    parameter int MTYPE_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               loaduse_hazard_i,
    input  logic               je_i,
    input  logic [XLEN-1:0]    jump_addr_i,
    input  logic               mtype_start_i,
    input  logic               mtype_done_i,
    input  logic               ext_stall_i,
    input  logic               trap_taken_i,
    input  logic [XLEN-1:0]    trap_entry_i,
    input  logic               system_ret_i,
    input  logic [XLEN-1:0]    system_retaddr_i,
    output logic [NSTAGES-1:0] stall_o,
    output logic [NSTAGES-1:0] flush_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_addr_o,
    output logic [1:0]         redirect_cause_o,
    output logic               mtype_busy_o,
    output logic               mtype_kill_o,
    output logic               mtype_timeout_o,
    output logic [31:0]        stall_cycles_o,
    output logic [31:0]        flush_events_o
);

    // Stages IF..last MEM. WB (top bit) and PC (bit 0) are never flushed.
    localparam logic [NSTAGES-1:0] MID_MASK = {1'b0, {(NSTAGES-2){1'b1}}, 1'b0};
    localparam logic [7:0]         CNT_LAST = 8'(MTYPE_TIMEOUT - 1);

    mstate_t             state;
    logic [7:0]          cnt;
    logic                kill_q;
    logic                tmo_q;

    logic                mstall;
    logic                hold;
    logic                stall_pc;
    logic                pending;
    logic [NSTAGES-1:0]  stall_raw;
    logic [NSTAGES-1:0]  flush_raw;

    logic                evt_valid;
    logic [1:0]          evt_cause;
    logic [XLEN-1:0]     evt_addr;

    // Redirect event priority: trap > ret > jump.
    always_comb begin
        evt_valid = trap_taken_i | system_ret_i | je_i;
        evt_cause = CAUSE_JUMP;
        evt_addr  = jump_addr_i;
        if (trap_taken_i) begin
            evt_cause = CAUSE_TRAP;
            evt_addr  = trap_entry_i;
        end else if (system_ret_i) begin
            evt_cause = CAUSE_RET;
            evt_addr  = system_retaddr_i;
        end
    end

    always_comb begin
        mstall    = mtype_start_i | ((state == ST_BUSY) & ~mtype_done_i);
        hold      = mstall | ext_stall_i;
        stall_raw = '0;
        flush_raw = '0;
        if (hold) begin
            stall_raw = '1;
        end
        if (loaduse_hazard_i) begin
            stall_raw[STG_PC] = 1'b1;
            stall_raw[STG_IF] = 1'b1;
            flush_raw[STG_ID] = 1'b1;
        end
        // A held redirect keeps squashing the wrong-path fetch/decode stages.
        if (je_i || pending) begin
            flush_raw[STG_IF] = 1'b1;
            flush_raw[STG_ID] = 1'b1;
        end
        if (trap_taken_i || system_ret_i) begin
            flush_raw = flush_raw | MID_MASK;
        end
    end

    // A flush bit overrides its stall bit. Bit 0 is never flushed.
    assign stall_o  = stall_raw & ~flush_raw;
    assign flush_o  = flush_raw;
    assign stall_pc = stall_raw[STG_PC];

    pipectrl_redirect_q #(
        .XLEN (XLEN)
    ) u_redirect_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_valid (evt_valid),
        .evt_cause (evt_cause),
        .evt_addr  (evt_addr),
        .stall_pc  (stall_pc),
        .valid     (redirect_valid_o),
        .cause     (redirect_cause_o),
        .addr      (redirect_addr_o),
        .pending   (pending)
    );

    // M-type FSM. A start that arrives together with done completes in one
    // cycle, so it stays in IDLE. A kill wins over done and over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            kill_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            kill_q <= 1'b0;
            tmo_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mtype_start_i && !mtype_done_i) begin
                        state <= ST_BUSY;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (trap_taken_i || system_ret_i) begin
                        state  <= ST_IDLE;
                        kill_q <= 1'b1;
                    end else if (mtype_done_i) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        tmo_q <= 1'b1;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mtype_busy_o    = (state == ST_BUSY);
    assign mtype_kill_o    = kill_q;
    assign mtype_timeout_o = tmo_q;

`ifdef PIPECTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Both counters saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect_valid_o && !stall_pc && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign flush_events_o = flush_cnt;
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_pipectrl_v2.sv
// tb_pipectrl_v2: directed self-checking bench for pipectrl_v2.
// The main instance uses the default timeout of 64. A second instance with
// MTYPE_TIMEOUT=4 shares the same inputs and is checked only on its M-type
// outputs. Inputs are driven on the falling edge, and all outputs are
// sampled 1 time unit later, well before the next rising edge.
module tb_pipectrl_v2;

    localparam int XLEN = 32;
    localparam int NS   = 6;

    logic            clk;
    logic            rst_n;
    logic            loaduse_hazard_i;
    logic            je_i;
    logic [XLEN-1:0] jump_addr_i;
    logic            mtype_start_i;
    logic            mtype_done_i;
    logic            ext_stall_i;
    logic            trap_taken_i;
    logic [XLEN-1:0] trap_entry_i;
    logic            system_ret_i;
    logic [XLEN-1:0] system_retaddr_i;

    logic [NS-1:0]   stall_o;
    logic [NS-1:0]   flush_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_addr_o;
    logic [1:0]      redirect_cause_o;
    logic            mtype_busy_o;
    logic            mtype_kill_o;
    logic            mtype_timeout_o;
    logic [31:0]     stall_cycles_o;
    logic [31:0]     flush_events_o;

    logic [NS-1:0]   t4_stall;
    logic [NS-1:0]   t4_flush;
    logic            t4_rvalid;
    logic [XLEN-1:0] t4_raddr;
    logic [1:0]      t4_rcause;
    logic            t4_busy;
    logic            t4_kill;
    logic            t4_timeout;
    logic [31:0]     t4_scyc;
    logic [31:0]     t4_fev;

    int checks;
    int errors;
    int exp_stall_cycles;
    int exp_flush_events;

    pipectrl_v2 #(.XLEN(XLEN), .NSTAGES(NS), .MTYPE_TIMEOUT(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .loaduse_hazard_i (loaduse_hazard_i),
        .je_i             (je_i),
        .jump_addr_i      (jump_addr_i),
        .mtype_start_i    (mtype_start_i),
        .mtype_done_i     (mtype_done_i),
        .ext_stall_i      (ext_stall_i),
        .trap_taken_i     (trap_taken_i),
        .trap_entry_i     (trap_entry_i),
        .system_ret_i     (system_ret_i),
        .system_retaddr_i (system_retaddr_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_addr_o  (redirect_addr_o),
        .redirect_cause_o (redirect_cause_o),
        .mtype_busy_o     (mtype_busy_o),
        .mtype_kill_o     (mtype_kill_o),
        .mtype_timeout_o  (mtype_timeout_o),
        .stall_cycles_o   (stall_cycles_o),
        .flush_events_o   (flush_events_o)
    );

    pipectrl_v2 #(.XLEN(XLEN), .NSTAGES(NS), .MTYPE_TIMEOUT(4)) dut_t4 (
        .clk              (clk),
        .rst_n            (rst_n),
        .loaduse_hazard_i (loaduse_hazard_i),
        .je_i             (je_i),
        .jump_addr_i      (jump_addr_i),
        .mtype_start_i    (mtype_start_i),
        .mtype_done_i     (mtype_done_i),
        .ext_stall_i      (ext_stall_i),
        .trap_taken_i     (trap_taken_i),
        .trap_entry_i     (trap_entry_i),
        .system_ret_i     (system_ret_i),
        .system_retaddr_i (system_retaddr_i),
        .stall_o          (t4_stall),
        .flush_o          (t4_flush),
        .redirect_valid_o (t4_rvalid),
        .redirect_addr_o  (t4_raddr),
        .redirect_cause_o (t4_rcause),
        .mtype_busy_o     (t4_busy),
        .mtype_kill_o     (t4_kill),
        .mtype_timeout_o  (t4_timeout),
        .stall_cycles_o   (t4_scyc),
        .flush_events_o   (t4_fev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        loaduse_hazard_i = 1'b0;
        je_i             = 1'b0;
        jump_addr_i      = '0;
        mtype_start_i    = 1'b0;
        mtype_done_i     = 1'b0;
        ext_stall_i      = 1'b0;
        trap_taken_i     = 1'b0;
        trap_entry_i     = '0;
        system_ret_i     = 1'b0;
        system_retaddr_i = '0;
    endtask

    // Start a new cycle on the falling edge with every input idle.
    task automatic cyc();
        @(negedge clk);
        clr();
    endtask

    task automatic chk_redir(input string tag, input logic v, input logic [31:0] a,
                             input logic [1:0] c);
        check({tag, "_rvalid"}, 64'(redirect_valid_o), 64'(v));
        check({tag, "_raddr"},  64'(redirect_addr_o),  64'(a));
        check({tag, "_rcause"}, 64'(redirect_cause_o), 64'(c));
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        exp_stall_cycles = 0;
        exp_flush_events = 0;
        clr();
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall_o), 64'h0);
        check("rst_flush", 64'(flush_o), 64'h0);
        chk_redir("rst", 1'b0, 32'h0, 2'd0);
        check("rst_busy", 64'(mtype_busy_o), 64'h0);
        check("rst_kill", 64'(mtype_kill_o), 64'h0);
        check("rst_tmo", 64'(mtype_timeout_o), 64'h0);
        check("rst_scyc", 64'(stall_cycles_o), 64'h0);
        check("rst_fev", 64'(flush_events_o), 64'h0);
        cyc();
        rst_n = 1'b1;

        // A jump with no stall is delivered in the same cycle
        cyc(); je_i = 1'b1; jump_addr_i = 32'h100; #1;
        chk_redir("je", 1'b1, 32'h100, 2'd0);
        check("je_flush", 64'(flush_o), 64'h06);
        check("je_stall", 64'(stall_o), 64'h00);
        exp_flush_events++;
        cyc(); #1;
        check("je_after_rvalid", 64'(redirect_valid_o), 64'h0);

        // Load-use hazard
        cyc(); loaduse_hazard_i = 1'b1; #1;
        check("lu_stall", 64'(stall_o), 64'h03);
        check("lu_flush", 64'(flush_o), 64'h04);
        check("lu_rvalid", 64'(redirect_valid_o), 64'h0);
        exp_stall_cycles++;

        // Multi-cycle M-type op: start at t0, done at t0+5
        cyc(); mtype_start_i = 1'b1; #1;
        check("mt_t0_stall", 64'(stall_o), 64'h3F);
        check("mt_t0_busy", 64'(mtype_busy_o), 64'h0);
        exp_stall_cycles++;
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            check($sformatf("mt_t%0d_stall", i), 64'(stall_o), 64'h3F);
            check($sformatf("mt_t%0d_busy", i), 64'(mtype_busy_o), 64'h1);
            exp_stall_cycles++;
        end
        cyc(); mtype_done_i = 1'b1; #1;
        check("mt_done_stall", 64'(stall_o), 64'h00);
        cyc(); #1;
        check("mt_after_busy", 64'(mtype_busy_o), 64'h0);

        // A jump held by ext_stall is replaced by a later trap
        cyc(); ext_stall_i = 1'b1; #1;
        check("pd_s0_stall", 64'(stall_o), 64'h3F);
        check("pd_s0_rvalid", 64'(redirect_valid_o), 64'h0);
        exp_stall_cycles++;
        cyc(); ext_stall_i = 1'b1; je_i = 1'b1; jump_addr_i = 32'h200; #1;
        check("pd_s1_stall", 64'(stall_o), 64'h39);
        check("pd_s1_flush", 64'(flush_o), 64'h06);
        check("pd_s1_rvalid", 64'(redirect_valid_o), 64'h0);
        exp_stall_cycles++;
        cyc(); ext_stall_i = 1'b1; trap_taken_i = 1'b1; trap_entry_i = 32'h80; #1;
        check("pd_s2_stall", 64'(stall_o), 64'h21);
        check("pd_s2_flush", 64'(flush_o), 64'h1E);
        chk_redir("pd_s2", 1'b1, 32'h200, 2'd0);
        exp_stall_cycles++;
        cyc(); #1;
        chk_redir("pd_out", 1'b1, 32'h80, 2'd2);
        check("pd_out_flush", 64'(flush_o), 64'h06);
        check("pd_out_stall", 64'(stall_o), 64'h00);
        exp_flush_events++;
        cyc(); #1;
        check("pd_clear_rvalid", 64'(redirect_valid_o), 64'h0);
        check("pd_clear_flush", 64'(flush_o), 64'h00);

        // Timeout on the 4-cycle instance
        cyc(); mtype_start_i = 1'b1; #1;
        check("to_t0_stall", 64'(t4_stall), 64'h3F);
        exp_stall_cycles++;
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            check($sformatf("to_t%0d_busy", i), 64'(t4_busy), 64'h1);
            check($sformatf("to_t%0d_stall", i), 64'(t4_stall), 64'h3F);
            check($sformatf("to_t%0d_tmo", i), 64'(t4_timeout), 64'h0);
            exp_stall_cycles++;
        end
        // The main instance is still busy, so done releases it here
        cyc(); mtype_done_i = 1'b1; #1;
        check("to_pulse", 64'(t4_timeout), 64'h1);
        check("to_idle", 64'(t4_busy), 64'h0);
        check("to_kill", 64'(t4_kill), 64'h0);
        cyc(); #1;
        check("to_pulse_end", 64'(t4_timeout), 64'h0);

        // A trap during BUSY kills the op
        cyc(); mtype_start_i = 1'b1; #1;
        exp_stall_cycles++;
        cyc(); #1; exp_stall_cycles++;
        cyc(); #1; exp_stall_cycles++;
        cyc(); trap_taken_i = 1'b1; trap_entry_i = 32'h80; #1;
        check("kl_stall", 64'(stall_o), 64'h21);
        check("kl_rvalid", 64'(redirect_valid_o), 64'h0);
        exp_stall_cycles++;
        cyc(); #1;
        check("kl_kill", 64'(mtype_kill_o), 64'h1);
        check("kl_tmo", 64'(mtype_timeout_o), 64'h0);
        check("kl_busy", 64'(mtype_busy_o), 64'h0);
        check("kl_t4_kill", 64'(t4_kill), 64'h1);
        check("kl_t4_tmo", 64'(t4_timeout), 64'h0);
        chk_redir("kl_out", 1'b1, 32'h80, 2'd2);
        exp_flush_events++;
        cyc(); #1;
        check("kl_kill_end", 64'(mtype_kill_o), 64'h0);

        // Same-cycle priority: a return beats a jump
        cyc(); je_i = 1'b1; jump_addr_i = 32'h300; system_ret_i = 1'b1;
        system_retaddr_i = 32'h444; #1;
        chk_redir("pr", 1'b1, 32'h444, 2'd1);
        check("pr_flush", 64'(flush_o), 64'h1E);
        exp_flush_events++;

        // Performance counters
        cyc(); #1;
`ifdef PIPECTRL_PERF_EN
        check("perf_scyc", 64'(stall_cycles_o), 64'(exp_stall_cycles));
        check("perf_fev", 64'(flush_events_o), 64'(exp_flush_events));
`else
        check("perf_scyc_off", 64'(stall_cycles_o), 64'h0);
        check("perf_fev_off", 64'(flush_events_o), 64'h0);
`endif

        // A reset while a redirect is pending discards that redirect
        cyc(); ext_stall_i = 1'b1; je_i = 1'b1; jump_addr_i = 32'h500; #1;
        cyc(); ext_stall_i = 1'b1; #1;
        check("rp_pending", 64'(redirect_valid_o), 64'h1);
        rst_n = 1'b0;
        cyc(); #1;
        rst_n = 1'b1;
        cyc(); #1;
        chk_redir("rp_after", 1'b0, 32'h0, 2'd0);
        check("rp_flush", 64'(flush_o), 64'h00);
        check("rp_scyc", 64'(stall_cycles_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
